// File: rtl/xgmii_link_fault_pkg.sv
// Shared types and constants for the XGMII link fault block.
// Holds the state encoding, fault type codes, fixed TX words and the column step state record.
package xgmii_link_fault_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] FLT_OK     = 2'b00;
  localparam logic [1:0] FLT_LOCAL  = 2'b01;
  localparam logic [1:0] FLT_REMOTE = 2'b10;

  localparam logic [7:0]  SEQ_CTRL    = 8'h9C;
  localparam logic [7:0]  IDLE        = 8'h07;
  localparam logic [63:0] IDLE_WORD   = {8{IDLE}};
  localparam logic [7:0]  IDLE_TXC    = 8'hFF;
  localparam logic [63:0] RFAULT_WORD = 64'h0200009C_0200009C;
  localparam logic [7:0]  RFAULT_TXC  = 8'h11;

  typedef struct packed {
    state_t      state;
    logic [1:0]  last_type;
    logic [2:0]  seq_cnt;
    logic [7:0]  col_cnt;
    logic [1:0]  link_fault;
    logic [15:0] fault_cnt;
  } lf_state_t;

  localparam lf_state_t LF_RESET = '{
    state:      ST_INIT,
    last_type:  2'b00,
    seq_cnt:    3'd0,
    col_cnt:    8'd0,
    link_fault: FLT_OK,
    fault_cnt:  16'd0
  };

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xgmii_link_fault_seq_detect.sv
// Decodes one XGMII column into a sequence-ordered-set flag and its fault type.
// Purely combinational; unknown byte-3 codes are reported as non-sequence.
module xgmii_seq_detect
  import xgmii_link_fault_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic [3:0]  i_ctl,
  output logic        o_is_seq,
  output logic [1:0]  o_type
);

  logic       w_frame_ok;
  logic [7:0] w_code;

  assign w_code     = i_col[31:24];
  assign w_frame_ok = (i_col[7:0] == SEQ_CTRL) && (i_ctl == 4'b0001) && (i_col[23:8] == 16'h0000);

  always_comb begin
    o_type = FLT_OK;
    if (w_code == 8'h01)      o_type = FLT_LOCAL;
    else if (w_code == 8'h02) o_type = FLT_REMOTE;
  end

  assign o_is_seq = w_frame_ok && (o_type != FLT_OK);

endmodule

// File: rtl/xgmii_link_fault.sv
// XGMII RS link fault detection with TX fault signalling; two columns processed per clock.
// Status and TX outputs are registered with one-cycle latency; no backpressure.
module xgmii_link_fault
  import xgmii_link_fault_pkg::*;
#(
  parameter int C_SEQ_THRESH = 4,
  parameter int C_COL_LIMIT  = 128
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [1:0]  link_fault,
  output logic        link_up,
  output logic [15:0] fault_cnt
);

  localparam logic [2:0] SEQ_THRESH = 3'(C_SEQ_THRESH);
  localparam logic [7:0] COL_LIMIT  = 8'(C_COL_LIMIT);

  logic       w_seq0, w_seq1;
  logic [1:0] w_type0, w_type1;
  lf_state_t  w_mid, w_nxt;
  lf_state_t  r_st;
  logic       r_link_up;
  logic [63:0] r_txd;
  logic [7:0]  r_txc;

  xgmii_seq_detect u_det0 (
    .i_col    (xgmii_rxd[31:0]),
    .i_ctl    (xgmii_rxc[3:0]),
    .o_is_seq (w_seq0),
    .o_type   (w_type0)
  );

  xgmii_seq_detect u_det1 (
    .i_col    (xgmii_rxd[63:32]),
    .i_ctl    (xgmii_rxc[7:4]),
    .o_is_seq (w_seq1),
    .o_type   (w_type1)
  );

  function automatic lf_state_t col_step(input lf_state_t s, input logic is_seq, input logic [1:0] t);
    lf_state_t n;
    n = s;
    case (s.state)
      ST_INIT: begin
        if (is_seq) begin
          n.last_type = t;
          n.seq_cnt   = 3'd1;
          n.col_cnt   = 8'd0;
          n.state     = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (is_seq && (t == s.last_type)) begin
          n.seq_cnt = s.seq_cnt + 3'd1;
          n.col_cnt = 8'd0;
          if (n.seq_cnt >= SEQ_THRESH) begin
            n.seq_cnt    = SEQ_THRESH;
            n.state      = ST_FAULT;
            n.link_fault = t;
            n.fault_cnt  = sat_inc16(s.fault_cnt);
          end
        end else if (is_seq) begin
          n.last_type = t;
          n.seq_cnt   = 3'd1;
          n.col_cnt   = 8'd0;
        end else begin
          n.col_cnt = s.col_cnt + 8'd1;
          if (n.col_cnt >= COL_LIMIT) begin
            n.state   = ST_INIT;
            n.seq_cnt = 3'd0;
            n.col_cnt = 8'd0;
          end
        end
      end
      ST_FAULT: begin
        if (is_seq && (t == s.last_type)) begin
          n.col_cnt = 8'd0;
        end else if (is_seq) begin
          // a type change restarts qualification but keeps signalling the old fault
          n.last_type = t;
          n.seq_cnt   = 3'd1;
          n.col_cnt   = 8'd0;
          n.state     = ST_COUNT;
        end else begin
          n.col_cnt = s.col_cnt + 8'd1;
          if (n.col_cnt >= COL_LIMIT) begin
            n.state      = ST_INIT;
            n.seq_cnt    = 3'd0;
            n.col_cnt    = 8'd0;
            n.link_fault = FLT_OK;
          end
        end
      end
      default: n = LF_RESET;
    endcase
    return n;
  endfunction

  always_comb begin
    w_mid = col_step(r_st, w_seq0, w_type0);
    w_nxt = col_step(w_mid, w_seq1, w_type1);
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      r_st      <= LF_RESET;
      r_link_up <= 1'b1;
      r_txd     <= IDLE_WORD;
      r_txc     <= IDLE_TXC;
    end else begin
      r_st      <= w_nxt;
      r_link_up <= (w_nxt.link_fault == FLT_OK);
      // whole-word override chosen from the already-registered fault status
      case (r_st.link_fault)
        FLT_OK: begin
          r_txd <= mac_txd;
          r_txc <= mac_txc;
        end
        FLT_LOCAL: begin
          r_txd <= RFAULT_WORD;
          r_txc <= RFAULT_TXC;
        end
        default: begin
          r_txd <= IDLE_WORD;
          r_txc <= IDLE_TXC;
        end
      endcase
    end
  end

  assign link_fault = r_st.link_fault;
  assign fault_cnt  = r_st.fault_cnt;
  assign link_up    = r_link_up;
  assign xgmii_txd  = r_txd;
  assign xgmii_txc  = r_txc;

endmodule

// File: tb/tb_xgmii_link_fault.sv
// Directed bench for xgmii_link_fault: fault qualification, clearing, TX override and reset.
module tb_xgmii_link_fault;

  localparam logic [31:0] C_LOC = 32'h0100009C;
  localparam logic [31:0] C_REM = 32'h0200009C;
  localparam logic [31:0] C_IDL = 32'h07070707;
  localparam logic [31:0] C_B3  = 32'h0300009C;
  localparam logic [31:0] C_B12 = 32'h0101009C;
  localparam logic [63:0] C_MAC_D = 64'hDEADBEEF_01234567;
  localparam logic [7:0]  C_MAC_C = 8'h01;
  localparam logic [63:0] C_IDLE_W = 64'h07070707_07070707;
  localparam logic [63:0] C_RF_W   = 64'h0200009C_0200009C;

  logic        clk156 = 1'b0;
  logic        reset;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] mac_txd;
  logic [7:0]  mac_txc;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [15:0] fault_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk156 = ~clk156;

  xgmii_link_fault dut (
    .clk156     (clk156),
    .reset      (reset),
    .xgmii_rxd  (xgmii_rxd),
    .xgmii_rxc  (xgmii_rxc),
    .mac_txd    (mac_txd),
    .mac_txc    (mac_txc),
    .xgmii_txd  (xgmii_txd),
    .xgmii_txc  (xgmii_txc),
    .link_fault (link_fault),
    .link_up    (link_up),
    .fault_cnt  (fault_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one word with explicit control nibbles, outputs settled 1 time unit after the edge
  task automatic wdk(input logic [31:0] c0, input logic [3:0] k0, input logic [31:0] c1, input logic [3:0] k1);
    xgmii_rxd = {c1, c0};
    xgmii_rxc = {k1, k0};
    @(posedge clk156);
    #1;
  endtask

  task automatic wd(input logic [31:0] c0, input logic [31:0] c1);
    wdk(c0, (c0 == C_IDL) ? 4'hF : 4'h1, c1, (c1 == C_IDL) ? 4'hF : 4'h1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) wd(C_IDL, C_IDL);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk156);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    xgmii_rxd = {C_IDL, C_IDL};
    xgmii_rxc = 8'hFF;
    mac_txd   = C_MAC_D;
    mac_txc   = C_MAC_C;

    @(posedge clk156);
    #1;
    chk("rst_fault",  64'(link_fault), 64'd0);
    chk("rst_up",     64'(link_up),    64'd1);
    chk("rst_cnt",    64'(fault_cnt),  64'd0);
    chk("rst_txd",    xgmii_txd,       C_IDLE_W);
    chk("rst_txc",    64'(xgmii_txc),  64'hFF);
    reset = 1'b0;
    wd(C_IDL, C_IDL);
    chk("ok_txd", xgmii_txd, C_MAC_D);
    chk("ok_txc", 64'(xgmii_txc), 64'(C_MAC_C));

    // local fault qualified by the 4th sequence, inside the 2nd word
    do_reset();
    wd(C_LOC, C_LOC);
    chk("loc_w1_fault", 64'(link_fault), 64'd0);
    wd(C_LOC, C_LOC);
    chk("loc_w2_fault", 64'(link_fault), 64'd1);
    chk("loc_w2_up",    64'(link_up),    64'd0);
    chk("loc_w2_txd",   xgmii_txd,       C_MAC_D);
    wd(C_LOC, C_LOC);
    chk("loc_w3_txd",   xgmii_txd,       C_RF_W);
    chk("loc_w3_txc",   64'(xgmii_txc),  64'h11);
    wd(C_LOC, C_LOC);
    chk("loc_cnt",      64'(fault_cnt),  64'd1);

    // clearing needs 128 fault-free columns
    idles(63);
    chk("clr_63_fault", 64'(link_fault), 64'd1);
    idles(1);
    chk("clr_64_fault", 64'(link_fault), 64'd0);
    chk("clr_64_up",    64'(link_up),    64'd1);
    chk("clr_64_txd",   xgmii_txd,       C_RF_W);
    idles(1);
    chk("clr_65_txd",   xgmii_txd,       C_MAC_D);
    chk("clr_cnt",      64'(fault_cnt),  64'd1);

    // 127 idle columns between 3rd and 4th sequence keeps the count
    do_reset();
    wd(C_LOC, C_LOC);
    wd(C_LOC, C_IDL);
    idles(63);
    wd(C_LOC, C_IDL);
    chk("gap127_fault", 64'(link_fault), 64'd1);

    // 128 idle columns abandons it: 4th sequence restarts at 1
    do_reset();
    wd(C_LOC, C_LOC);
    wd(C_LOC, C_IDL);
    idles(63);
    wd(C_IDL, C_LOC);
    chk("gap128_fault", 64'(link_fault), 64'd0);
    wd(C_LOC, C_LOC);
    chk("gap128_seq3",  64'(link_fault), 64'd0);
    wd(C_LOC, C_IDL);
    chk("gap128_seq4",  64'(link_fault), 64'd1);

    // alternating remote/local never qualifies
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) wd(C_REM, C_REM);
      else            wd(C_LOC, C_LOC);
    end
    chk("alt_fault", 64'(link_fault), 64'd0);
    chk("alt_cnt",   64'(fault_cnt),  64'd0);
    chk("alt_up",    64'(link_up),    64'd1);

    // type change while in fault keeps old status until the new type qualifies
    do_reset();
    wd(C_LOC, C_LOC);
    wd(C_LOC, C_LOC);
    wd(C_REM, C_REM);
    chk("chg_keep",  64'(link_fault), 64'd1);
    wd(C_REM, C_REM);
    chk("chg_rem",   64'(link_fault), 64'd2);
    chk("chg_cnt",   64'(fault_cnt),  64'd2);

    // remote fault, then reset mid-fault
    do_reset();
    wd(C_REM, C_REM);
    wd(C_REM, C_REM);
    chk("rem_fault", 64'(link_fault), 64'd2);
    wd(C_REM, C_REM);
    chk("rem_txd",   xgmii_txd,       C_IDLE_W);
    chk("rem_txc",   64'(xgmii_txc),  64'hFF);
    chk("rem_cnt",   64'(fault_cnt),  64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_fault", 64'(link_fault), 64'd0);
    chk("mid_rst_up",    64'(link_up),    64'd1);
    chk("mid_rst_cnt",   64'(fault_cnt),  64'd0);
    chk("mid_rst_txd",   xgmii_txd,       C_IDLE_W);
    @(posedge clk156);
    #1;
    reset = 1'b0;
    wd(C_LOC, C_LOC);
    chk("post_rst_w1", 64'(link_fault), 64'd0);
    wd(C_LOC, C_LOC);
    chk("post_rst_w2", 64'(link_fault), 64'd1);

    // malformed sequence columns never advance the machine
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wd(C_B3, C_B12);
      wdk(C_LOC, 4'h0, C_LOC, 4'h0);
    end
    chk("bad_only", 64'(link_fault), 64'd0);
    wd(C_LOC, C_B3);
    wd(C_LOC, C_B12);
    wdk(C_LOC, 4'h1, C_LOC, 4'h0);
    chk("bad_mix3", 64'(link_fault), 64'd0);
    wd(C_LOC, C_B3);
    chk("bad_mix4", 64'(link_fault), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
